// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and mem_responder.
// Signal names follow the initiator-facing protocol so both sides read naturally.
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake,
// with a fixed number of wait states between accept and response.
module mem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic        r_rd_zero;
    logic [31:0] r_rd_q;
    logic [31:0] r_mem [DEPTH];

    logic          w_accept;
    logic          w_enter_resp;
    logic          w_op_write;
    logic [31:0]   w_op_addr;
    logic [31:0]   w_op_wdata;
    logic          w_op_err;
    logic [AW-1:0] w_idx;
    logic          w_mem_we;
    logic          w_mem_re;

    assign w_accept = (r_state == IDLE) && bus.req_valid;

    // With zero wait states RESP is entered on the accept edge itself, so the
    // operation must come straight from the bus rather than the latched copy.
    assign w_op_write = (r_state == IDLE) ? bus.req_write : r_write;
    assign w_op_addr  = (r_state == IDLE) ? bus.req_addr  : r_addr;
    assign w_op_wdata = (r_state == IDLE) ? bus.req_wdata : r_wdata;

    assign w_op_err = (w_op_addr[1:0] != 2'b00) || (w_op_addr[31:2] >= 30'(DEPTH));
    assign w_idx    = w_op_addr[AW+1:2];

    assign w_enter_resp = (WAIT_CYCLES == 0) ? w_accept
                                             : ((r_state == WAIT) && (r_cnt == 4'd0));

    // Gating with reset keeps an abort in WAIT from landing a write on the same edge.
    assign w_mem_we = w_enter_resp && w_op_write  && !w_op_err && !reset;
    assign w_mem_re = w_enter_resp && !w_op_write && !w_op_err && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_write   <= 1'b0;
            r_addr    <= 32'd0;
            r_wdata   <= 32'd0;
            r_err     <= 1'b0;
            r_rd_zero <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_write <= bus.req_write;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        if (WAIT_CYCLES > 0) begin
                            r_state <= WAIT;
                            r_cnt   <= 4'(WAIT_CYCLES - 1);
                        end else begin
                            r_state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Response status is frozen from the entering edge until the next one.
            if (w_enter_resp) begin
                r_err     <= w_op_err;
                r_rd_zero <= w_op_write || w_op_err;
            end
        end
    end

    // Storage has no reset so it maps onto block RAM with a registered read.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= w_op_wdata;
        end
        if (w_mem_re) begin
            r_rd_q <= r_mem[w_idx];
        end
    end

    assign bus.req_ready = (r_state == IDLE);
    assign bus.rsp_valid = (r_state == RESP);
    assign bus.busy      = (r_state != IDLE);
    assign bus.rsp_err   = r_err;
    assign bus.rsp_rdata = r_rd_zero ? 32'd0 : r_rd_q;
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, giving the number of 32-bit words of storage.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the wait states between accept and response (legal range 0..15).
REQ-003 The block SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1, meaning the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1, meaning the responder can accept a request.
REQ-007 The block SHALL have port req_write, input, 1, selecting the operation: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, 32, the byte address.
REQ-009 The block SHALL have port req_wdata, input, 32, the store data.
REQ-010 The block SHALL have port rsp_valid, output, 1, meaning a response is presented.
REQ-011 The block SHALL have port rsp_ready, input, 1, meaning the initiator accepts the response.
REQ-012 The block SHALL have port rsp_rdata, output, 32, the load data.
REQ-013 The block SHALL have port rsp_err, output, 1, flagging a misaligned or out-of-range access.
REQ-014 The block SHALL have port busy, output, 1, asserted whenever state is not IDLE.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 in IDLE only; rsp_valid SHALL be 1 in RESP only.
REQ-017 Accept SHALL occur on an edge where req_valid=1 and req_ready=1; req_write, req_addr and req_wdata SHALL be latched at accept.
REQ-018 On accept, next state SHALL be WAIT with wait counter loaded to WAIT_CYCLES-1 when WAIT_CYCLES>0, else RESP directly.
REQ-019 WAIT SHALL decrement the counter each edge and move to RESP on the edge where the counter equals 0.
REQ-020 rsp_valid SHALL first assert WAIT_CYCLES+1 edges after the accept edge.
REQ-021 Error SHALL be computed from the latched address: err = (addr[1:0]!=0) or (addr[31:2] >= DEPTH).
REQ-022 On the edge entering RESP: a store without error SHALL write word addr[31:2]; a load without error SHALL capture that word into rsp_rdata; an error SHALL capture rsp_rdata=0 and write nothing.
REQ-023 A store response SHALL return rsp_rdata=0.
REQ-024 rsp_rdata and rsp_err SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-025 On an edge in RESP with rsp_ready=1, state SHALL return to IDLE, making back-to-back requests possible at one per WAIT_CYCLES+2 edges.
REQ-026 req_valid in WAIT or RESP SHALL be ignored (not accepted, not lost); the initiator holds it.
REQ-027 rsp_ready while not in RESP SHALL have no effect.
REQ-028 Storage SHALL be word-addressed, whole-word writes only; no byte enables.

Reset
REQ-029 Reset SHALL force state IDLE, wait counter 0, rsp_rdata 0 and rsp_err 0, giving req_ready=1, rsp_valid=0 and busy=0.
REQ-030 Storage contents SHALL NOT be affected by reset.
REQ-031 Reset asserted in WAIT SHALL abort the transaction with no storage write.

Verification
REQ-032 Store of 7 to 0x64 at WAIT_CYCLES=2 with rsp_ready=1 -> rsp_valid on 3rd edge after accept, rsp_err=0, rsp_rdata=0; IDLE on the following edge.
REQ-033 Load from 0x64 after that store -> rsp_rdata=0x00000007, rsp_err=0.
REQ-034 Store of 0xDEADBEEF to 0x62, then load from 0x60 -> first response rsp_err=1; load returns the prior content, unchanged.
REQ-035 Load from 0x100 (word 64, DEPTH=64) -> rsp_err=1, rsp_rdata=0.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err held and req_ready=0 throughout; a pending req_valid is accepted only after the IDLE return.
REQ-037 Reset pulse during WAIT of a store of 0x55 to 0x08, then load from 0x08 -> req_ready=1 immediately after reset; load returns the pre-store value.
